// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

    // Clear sequencer states: sweep storage to zero, then normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Architectural zero register; never written, never busy.
    localparam int REG_ZERO  = 0;

endpackage

// File: rtl/regfile_cell.sv
// One storage entry. No reset: the clear sweep zeroes it after reset.
module regfile_cell #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            we,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    // Capture write data when this entry is selected.
    always_ff @(posedge clk) begin
        if (we) q <= d;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking in-flight producers, with per-port lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 wr_ena,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 rsv_ena,
    input  logic [AW-1:0]        rsv_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy;
    logic             wr_hit;
    logic             rsv_hit;

    assign wr_hit  = run && wr_ena  && (wr_addr  != AW'(REG_ZERO));
    assign rsv_hit = run && rsv_ena && (rsv_addr != AW'(REG_ZERO));

    // Reservation beats the write's clear when both target the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int e = 0; e < NREGS; e++) begin
                if (rsv_hit && rsv_addr == AW'(e))
                    busy[e] <= 1'b1;
                else if (wr_hit && wr_addr == AW'(e))
                    busy[e] <= 1'b0;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_look
        logic [AW-1:0] ra;
        logic          busy_p;

        assign ra = rd_addr[p*AW +: AW];

        // A bypassed write means the value is here now, so it is not busy.
        always_comb begin
            busy_p = 1'b0;
            if (run && ra != AW'(REG_ZERO)) begin
                busy_p = busy[ra];
                if (BYPASS != 0 && wr_hit && wr_addr == ra)
                    busy_p = 1'b0;
            end
        end

        assign rd_busy[p] = busy_p;
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with busy scoreboard and post-reset clear sweep.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   wr_ena,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   rsv_ena,
    input  logic [AW-1:0]          rsv_addr,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy
);

    rf_state_e        state, state_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic             run;
    logic             wr_hit;
    logic [NREGS-1:1] we;
    logic [XLEN-1:0]  cell_d;
    logic [XLEN-1:0]  regs [NREGS];

    assign run    = (state == RUN);
    assign ready  = run;
    assign wr_hit = run && wr_ena && (wr_addr != AW'(REG_ZERO));
    assign cell_d = run ? wr_data : '0;

    // State and sweep counter; reset restarts the sweep at entry 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= AW'(1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sweep one entry per cycle; leave CLEAR after the last entry is zeroed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == CLEAR) begin
            cnt_nxt = cnt + AW'(1);
            if (cnt == AW'(NREGS - 1))
                state_nxt = RUN;
        end
    end

    // Per-entry write enable: sweep pointer in CLEAR, write port in RUN.
    always_comb begin
        we = '0;
        for (int e = 1; e < NREGS; e++) begin
            if (!rst)
                we[e] = run ? (wr_hit && wr_addr == AW'(e)) : (cnt == AW'(e));
        end
    end

    assign regs[0] = '0;

    for (genvar g = 1; g < NREGS; g++) begin : g_cell
        regfile_cell #(.XLEN(XLEN)) u_cell (
            .clk (clk),
            .we  (we[g]),
            .d   (cell_d),
            .q   (regs[g])
        );
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] data_p;

        assign ra = rd_addr[p*AW +: AW];

        // Read mux: zero while clearing or for x0, bypass, else storage.
        always_comb begin
            data_p = '0;
            if (run && ra != AW'(REG_ZERO)) begin
                if (BYPASS != 0 && wr_hit && wr_addr == ra)
                    data_p = wr_data;
                else
                    data_p = regs[ra];
            end
        end

        assign rd_data[p*XLEN +: XLEN] = data_p;
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .rsv_ena  (rsv_ena),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: default bypass build, no-bypass build, and a 64x16x3 build.
module tb_register_file_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32x32x2 stimulus shared by the bypass and no-bypass instances
    logic        wr_ena = 1'b0, rsv_ena = 1'b0;
    logic [4:0]  wr_addr = '0, rsv_addr = '0;
    logic [31:0] wr_data = '0;
    logic [9:0]  rd_addr = '0;
    logic        rdy0, rdy1;
    logic [63:0] rdd0, rdd1;
    logic [1:0]  rdb0, rdb1;

    // 64x16x3 stimulus
    logic         wr2_ena = 1'b0, rsv2_ena = 1'b0;
    logic [3:0]   wr2_addr = '0, rsv2_addr = '0;
    logic [63:0]  wr2_data = '0;
    logic [11:0]  rd2_addr = '0;
    logic         rdy2;
    logic [191:0] rdd2;
    logic [2:0]   rdb2;

    register_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1)) u0 (
        .clk(clk), .rst(rst), .ready(rdy0), .wr_ena(wr_ena), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_ena(rsv_ena), .rsv_addr(rsv_addr),
        .rd_addr(rd_addr), .rd_data(rdd0), .rd_busy(rdb0));

    register_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .ready(rdy1), .wr_ena(wr_ena), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_ena(rsv_ena), .rsv_addr(rsv_addr),
        .rd_addr(rd_addr), .rd_data(rdd1), .rd_busy(rdb1));

    register_file_mp #(.XLEN(64), .NREGS(16), .NUM_RD(3), .BYPASS(1)) u2 (
        .clk(clk), .rst(rst), .ready(rdy2), .wr_ena(wr2_ena), .wr_addr(wr2_addr),
        .wr_data(wr2_data), .rsv_ena(rsv2_ena), .rsv_addr(rsv2_addr),
        .rd_addr(rd2_addr), .rd_data(rdd2), .rd_busy(rdb2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Storage is all-zero once the sweep time has elapsed; before that every
    // read is zero. Busy flags are a set of reserved, not-yet-written registers.
    bit [31:0] a_mem  [32];
    bit        a_busy [32];
    int        a_edges = 0;
    bit        a_ready = 1'b0;

    bit [63:0] b_mem  [16];
    bit        b_busy [16];
    int        b_edges = 0;
    bit        b_ready = 1'b0;

    // Model for the two 32-entry instances
    always @(posedge clk) begin
        if (rst) begin
            a_edges <= 0;
            a_ready <= 1'b0;
            for (int i = 0; i < 32; i++) a_busy[i] <= 1'b0;
        end else if (!a_ready) begin
            a_edges <= a_edges + 1;
            if (a_edges + 1 == 31) begin
                a_ready <= 1'b1;
                for (int i = 0; i < 32; i++) a_mem[i] <= '0;
            end
        end else begin
            if (wr_ena && wr_addr != 0) begin
                a_mem[wr_addr]  <= wr_data;
                a_busy[wr_addr] <= 1'b0;
            end
            if (rsv_ena && rsv_addr != 0) a_busy[rsv_addr] <= 1'b1;
        end
    end

    // Model for the 16-entry instance
    always @(posedge clk) begin
        if (rst) begin
            b_edges <= 0;
            b_ready <= 1'b0;
            for (int i = 0; i < 16; i++) b_busy[i] <= 1'b0;
        end else if (!b_ready) begin
            b_edges <= b_edges + 1;
            if (b_edges + 1 == 15) begin
                b_ready <= 1'b1;
                for (int i = 0; i < 16; i++) b_mem[i] <= '0;
            end
        end else begin
            if (wr2_ena && wr2_addr != 0) begin
                b_mem[wr2_addr]  <= wr2_data;
                b_busy[wr2_addr] <= 1'b0;
            end
            if (rsv2_ena && rsv2_addr != 0) b_busy[rsv2_addr] <= 1'b1;
        end
    end

    function automatic void exp_a(input int a, input bit byp,
                                  output logic [31:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (!a_ready || a == 0) return;
        if (byp && wr_ena === 1'b1 && wr_addr == a) begin
            d = wr_data;
            return;
        end
        d = a_mem[a];
        b = a_busy[a];
    endfunction

    function automatic void exp_b(input int a, output logic [63:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (!b_ready || a == 0) return;
        if (wr2_ena === 1'b1 && wr2_addr == a) begin
            d = wr2_data;
            return;
        end
        d = b_mem[a];
        b = b_busy[a];
    endfunction

    // Compare every output of every instance against the model each cycle
    always @(negedge clk) begin
        logic [31:0] ed;
        logic [63:0] ed64;
        logic        eb;
        chk("u0 ready", {63'd0, rdy0}, {63'd0, a_ready});
        chk("u1 ready", {63'd0, rdy1}, {63'd0, a_ready});
        chk("u2 ready", {63'd0, rdy2}, {63'd0, b_ready});
        for (int p = 0; p < 2; p++) begin
            exp_a(int'(rd_addr[p*5 +: 5]), 1'b1, ed, eb);
            chk($sformatf("u0 rd_data[%0d]", p), {32'd0, rdd0[p*32 +: 32]}, {32'd0, ed});
            chk($sformatf("u0 rd_busy[%0d]", p), {63'd0, rdb0[p]}, {63'd0, eb});
            exp_a(int'(rd_addr[p*5 +: 5]), 1'b0, ed, eb);
            chk($sformatf("u1 rd_data[%0d]", p), {32'd0, rdd1[p*32 +: 32]}, {32'd0, ed});
            chk($sformatf("u1 rd_busy[%0d]", p), {63'd0, rdb1[p]}, {63'd0, eb});
        end
        for (int p = 0; p < 3; p++) begin
            exp_b(int'(rd2_addr[p*4 +: 4]), ed64, eb);
            chk($sformatf("u2 rd_data[%0d]", p), rdd2[p*64 +: 64], ed64);
            chk($sformatf("u2 rd_busy[%0d]", p), {63'd0, rdb2[p]}, {63'd0, eb});
        end
    end

    // ---------------- directed stimulus ----------------
    // Inputs change 2 time units after the rising edge, away from both edges.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    // Count edges until u0 reports ready; records when u2 became ready too.
    task automatic wait_ready(output int n, output int n2);
        n  = 0;
        n2 = 0;
        while (rdy0 !== 1'b1 && n < 100) begin
            step();
            n++;
            if (rdy2 === 1'b1 && n2 == 0) n2 = n;
        end
    endtask

    initial begin
        int n, n2;

        // Reset held three edges, then release and time the sweep
        repeat (3) step();
        rst = 1'b0;
        wait_ready(n, n2);
        chk("sweep edges 32 regs", 64'(n), 64'd31);
        chk("sweep edges 16 regs", 64'(n2), 64'd15);

        // All registers read zero on both ports after the sweep
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            #1;
            chk("zero after sweep", rdd0, 64'd0);
            step();
        end

        // Reset from RUN, issue write/reserve during CLEAR, pulse reset at edge 15
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA;
        rsv_ena = 1'b1; rsv_addr = 5'd4;
        rd(5'd3, 5'd4);
        repeat (15) step();
        chk("not ready at edge 15", {63'd0, rdy0}, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(n, n2);
        chk("restart sweep edges", 64'(n), 64'd31);
        wr_ena = 1'b0; rsv_ena = 1'b0;
        #1;
        chk("x3 ignored in clear", rdd0, 64'd0);
        chk("x4 rsv ignored in clear", {62'd0, rdb0}, 64'd0);
        step();

        // Same-cycle write with bypass vs without
        wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rd(5'd5, 5'd5);
        #1;
        chk("bypass same cycle", rdd0, 64'hDEADBEEF_DEADBEEF);
        chk("no bypass same cycle", rdd1, 64'd0);
        step();
        wr_ena = 1'b0;
        #1;
        chk("no bypass next cycle", rdd1[31:0], 64'hDEADBEEF);
        step();

        // x0 immunity to writes and reservations
        wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rsv_ena = 1'b1; rsv_addr = 5'd0;
        rd(5'd0, 5'd0);
        #1;
        chk("x0 data same cycle", rdd0, 64'd0);
        step();
        wr_ena = 1'b0; rsv_ena = 1'b0;
        #1;
        chk("x0 data after", rdd0, 64'd0);
        chk("x0 busy after", {62'd0, rdb0}, 64'd0);
        step();

        // Scoreboard: reserve then write x7
        rsv_ena = 1'b1; rsv_addr = 5'd7;
        rd(5'd7, 5'd7);
        #1;
        chk("x7 busy same cycle", {62'd0, rdb0}, 64'd0);
        step();
        rsv_ena = 1'b0;
        #1;
        chk("x7 busy next cycle", {62'd0, rdb0}, 64'd3);
        step();
        wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
        #1;
        chk("x7 bypass busy masked", {62'd0, rdb0}, 64'd0);
        chk("x7 no-bypass still busy", {62'd0, rdb1}, 64'd3);
        step();
        wr_ena = 1'b0;
        #1;
        chk("x7 data after write", rdd1, 64'h00000012_00000012);
        chk("x7 busy after write", {62'd0, rdb1}, 64'd0);
        step();

        // Reserve and write x9 together: busy stays, data stored
        rsv_ena = 1'b1; rsv_addr = 5'd9;
        wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        rd(5'd5, 5'd9);
        step();
        rsv_ena = 1'b0; wr_ena = 1'b0;
        #1;
        chk("x9 data", rdd0, 64'h00000099_DEADBEEF);
        chk("x9 busy", {62'd0, rdb0}, 64'd2);
        step();

        // Reset in RUN discards busy state and re-zeroes storage
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(n, n2);
        chk("run reset sweep edges", 64'(n), 64'd31);
        chk("run reset sweep edges u2", 64'(n2), 64'd15);
        #1;
        chk("x9 cleared after reset", rdd0, 64'd0);
        chk("x9 busy cleared", {62'd0, rdb0}, 64'd0);
        step();

        // 64-bit, 16-entry, 3-port build
        rsv2_ena = 1'b1; rsv2_addr = 4'd15;
        wr2_ena = 1'b1; wr2_addr = 4'd1; wr2_data = 64'h11223344_55667788;
        step();
        rsv2_ena = 1'b0;
        wr2_addr = 4'd15; wr2_data = 64'hFEDCBA98_76543210;
        rd2_addr = {4'd15, 4'd1, 4'd1};
        #1;
        chk("u2 x15 bypass", rdd2[191:128], 64'hFEDCBA98_76543210);
        step();
        wr2_ena = 1'b0;
        #1;
        chk("u2 port0 x1", rdd2[63:0], 64'h11223344_55667788);
        chk("u2 port1 x1", rdd2[127:64], 64'h11223344_55667788);
        chk("u2 port2 x15", rdd2[191:128], 64'hFEDCBA98_76543210);
        chk("u2 busy", {61'd0, rdb2}, 64'd0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
